// File: rtl/serial_pattern_gen.sv
// Serial bit-stream transmitter: latches a pattern on start and shifts it out LSB-first,
// replaying it repeat_count+1 times with an optional idle gap between passes.
module serial_pattern_gen #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned LEN_W = 5,
    parameter int unsigned CNT_W = 4,
    parameter int unsigned GAP   = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] pattern,
    input  logic [LEN_W-1:0] length,
    input  logic [CNT_W-1:0] repeat_count,
    output logic             out,
    output logic             valid,
    output logic             busy,
    output logic             done
);

    localparam int unsigned GapW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [GapW-1:0] GapLast = GapW'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [LEN_W-1:0] LenMax = LEN_W'(WIDTH);

    typedef enum logic [1:0] {StIdle, StShift, StGapw, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pat_q, pat_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0] passes_q, passes_d;
    logic [GapW-1:0]  gap_cnt_q, gap_cnt_d;
    logic             out_q, out_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [LEN_W-1:0] len_sel;

    assign len_sel = (length > LenMax) ? LenMax : length;

    always_comb begin
        state_d   = state_q;
        pat_d     = pat_q;
        shift_d   = shift_q;
        len_d     = len_q;
        bit_cnt_d = bit_cnt_q;
        passes_d  = passes_q;
        gap_cnt_d = gap_cnt_q;
        out_d     = 1'b0;
        valid_d   = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b0;

        unique case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (start && !abort) begin
                    pat_d     = pattern;
                    shift_d   = pattern;
                    len_d     = len_sel;
                    passes_d  = repeat_count;
                    bit_cnt_d = '0;
                    gap_cnt_d = '0;
                    if (len_sel == '0) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                    end else begin
                        state_d = StShift;
                        out_d   = pattern[0];
                        valid_d = 1'b1;
                        busy_d  = 1'b1;
                    end
                end
            end

            StShift: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (bit_cnt_q == len_q - LEN_W'(1)) begin
                    if (passes_q == '0) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                    end else begin
                        passes_d = passes_q - CNT_W'(1);
                        busy_d   = 1'b1;
                        if (GAP > 0) begin
                            state_d   = StGapw;
                            gap_cnt_d = '0;
                        end else begin
                            // Next pass follows the last bit with no bubble.
                            shift_d   = pat_q;
                            bit_cnt_d = '0;
                            out_d     = pat_q[0];
                            valid_d   = 1'b1;
                        end
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + LEN_W'(1);
                    shift_d   = shift_q >> 1;
                    out_d     = shift_q[1];
                    valid_d   = 1'b1;
                    busy_d    = 1'b1;
                end
            end

            StGapw: begin
                busy_d = 1'b1;
                if (abort) begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
                end else if (gap_cnt_q == GapLast) begin
                    state_d   = StShift;
                    shift_d   = pat_q;
                    bit_cnt_d = '0;
                    out_d     = pat_q[0];
                    valid_d   = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q + GapW'(1);
                end
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= StIdle;
            pat_q     <= '0;
            shift_q   <= '0;
            len_q     <= '0;
            bit_cnt_q <= '0;
            passes_q  <= '0;
            gap_cnt_q <= '0;
            out_q     <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pat_q     <= pat_d;
            shift_q   <= shift_d;
            len_q     <= len_d;
            bit_cnt_q <= bit_cnt_d;
            passes_q  <= passes_d;
            gap_cnt_q <= gap_cnt_d;
            out_q     <= out_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign out   = out_q;
    assign valid = valid_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_serial_pattern_gen.sv
// Self-checking bench for serial_pattern_gen: one instance with GAP=0, one with GAP=2,
// each cycle compared against a per-cycle expectation built from the transmission rules.
module tb_serial_pattern_gen;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned LEN_W = 5;
    localparam int unsigned CNT_W = 4;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             abort = 1'b0;
    logic             start0 = 1'b0;
    logic             start2 = 1'b0;
    logic [WIDTH-1:0] pattern = '0;
    logic [LEN_W-1:0] length = '0;
    logic [CNT_W-1:0] repeat_count = '0;
    logic             out0, valid0, busy0, done0;
    logic             out2, valid2, busy2, done2;

    int total = 0;
    int bad = 0;
    // Each entry is {out, valid, busy, done} for one cycle.
    logic [3:0] exp_q[$];

    always #5 clock = ~clock;

    serial_pattern_gen #(.WIDTH(WIDTH), .LEN_W(LEN_W), .CNT_W(CNT_W), .GAP(0)) dut0 (
        .clock(clock), .reset(reset), .start(start0), .abort(abort), .pattern(pattern),
        .length(length), .repeat_count(repeat_count),
        .out(out0), .valid(valid0), .busy(busy0), .done(done0)
    );

    serial_pattern_gen #(.WIDTH(WIDTH), .LEN_W(LEN_W), .CNT_W(CNT_W), .GAP(2)) dut2 (
        .clock(clock), .reset(reset), .start(start2), .abort(abort), .pattern(pattern),
        .length(length), .repeat_count(repeat_count),
        .out(out2), .valid(valid2), .busy(busy2), .done(done2)
    );

    function automatic logic [3:0] observe(int sel);
        return (sel == 0) ? {out0, valid0, busy0, done0} : {out2, valid2, busy2, done2};
    endfunction

    task automatic check(string tag, int sel, logic [3:0] expected);
        logic [3:0] observed;
        observed = observe(sel);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s dut%0d observed={out,valid,busy,done}=%b expected=%b",
                   tag, sel * 2, observed, expected);
        end
    endtask

    task automatic set_start(int sel, logic v);
        if (sel == 0) start0 = v;
        else start2 = v;
    endtask

    // Expected stream from the edge that samples start up to and including the done pulse.
    task automatic build(logic [WIDTH-1:0] pat, int len_in, int rep, int gap);
        int len;
        len = (len_in > int'(WIDTH)) ? int'(WIDTH) : len_in;
        exp_q.delete();
        if (len > 0) begin
            for (int p = 0; p <= rep; p++) begin
                for (int i = 0; i < len; i++) exp_q.push_back({pat[i], 3'b110});
                if (p < rep) for (int g = 0; g < gap; g++) exp_q.push_back(4'b0010);
            end
        end
        exp_q.push_back(4'b0001);
    endtask

    task automatic run_job(string tag, int sel, logic [WIDTH-1:0] pat, int len, int rep,
                           bit noise, bit tail);
        build(pat, len, rep, (sel == 0) ? 0 : 2);
        pattern      = pat;
        length       = LEN_W'(len);
        repeat_count = CNT_W'(rep);
        set_start(sel, 1'b1);
        @(posedge clock); #1;
        set_start(sel, 1'b0);
        for (int j = 0; j < exp_q.size(); j++) begin
            if (j > 0) begin
                // Disturb start and the data inputs only while the DUT is busy.
                if (noise && exp_q[j-1][1]) begin
                    set_start(sel, 1'($urandom_range(0, 1)));
                    pattern      = WIDTH'($urandom);
                    length       = LEN_W'($urandom);
                    repeat_count = CNT_W'($urandom);
                end
                @(posedge clock); #1;
                set_start(sel, 1'b0);
            end
            check($sformatf("%s[%0d]", tag, j), sel, exp_q[j]);
        end
        if (tail) begin
            @(posedge clock); #1;
            check({tag, "_idle"}, sel, 4'b0000);
        end
    endtask

    initial begin
        int sel;
        int len;
        int rep;
        logic [WIDTH-1:0] pat;

        reset = 1'b1;
        start0 = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        start0 = 1'b0;
        check("reset", 0, 4'b0000);
        check("reset", 1, 4'b0000);

        run_job("single", 0, 16'h0006, 4, 0, 1'b0, 1'b1);
        run_job("gap2", 1, 16'h000D, 4, 1, 1'b0, 1'b1);
        run_job("b2b", 0, 16'h0003, 2, 2, 1'b0, 1'b1);
        run_job("len0", 0, 16'hFFFF, 0, 0, 1'b0, 1'b1);
        run_job("len20", 0, 16'hA5C3, 20, 0, 1'b0, 1'b1);
        run_job("len20g", 1, 16'h3C5A, 20, 1, 1'b0, 1'b1);
        run_job("maxrep", 0, 16'h0005, 3, 15, 1'b0, 1'b1);
        run_job("noise", 0, 16'h0B2D, 7, 1, 1'b1, 1'b1);
        run_job("noiseg", 1, 16'h00F1, 5, 2, 1'b1, 1'b1);
        run_job("chainA", 0, 16'h0002, 2, 0, 1'b0, 1'b0);
        run_job("chainB", 0, 16'h0005, 3, 0, 1'b0, 1'b1);
        run_job("stream", 0, 16'h001C, 8, 0, 1'b0, 1'b1);

        // Abort on the 3rd bit: everything drops next cycle and no done follows.
        pattern = 16'h00FF; length = 5'd8; repeat_count = '0;
        start0 = 1'b1;
        for (int b = 0; b < 3; b++) begin
            @(posedge clock); #1;
            start0 = 1'b0;
            check($sformatf("abort_bit%0d", b), 0, 4'b1110);
        end
        abort = 1'b1;
        @(posedge clock); #1;
        abort = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check($sformatf("abort_after%0d", c), 0, 4'b0000);
            @(posedge clock); #1;
        end

        // Abort during the gap of the GAP=2 instance.
        pattern = 16'h0001; length = 5'd1; repeat_count = 4'd1;
        start2 = 1'b1;
        @(posedge clock); #1;
        start2 = 1'b0;
        check("gabort_bit", 1, 4'b1110);
        @(posedge clock); #1;
        check("gabort_gap", 1, 4'b0010);
        abort = 1'b1;
        @(posedge clock); #1;
        abort = 1'b0;
        check("gabort_after", 1, 4'b0000);
        @(posedge clock); #1;
        check("gabort_nodone", 1, 4'b0000);

        // abort together with start in idle: nothing starts.
        abort = 1'b1; start0 = 1'b1; start2 = 1'b1;
        @(posedge clock); #1;
        abort = 1'b0; start0 = 1'b0; start2 = 1'b0;
        check("abort_start", 0, 4'b0000);
        check("abort_start", 1, 4'b0000);

        // Reset in the middle of a pass, then a normal job.
        pattern = 16'h7777; length = 5'd12; repeat_count = 4'd3;
        start0 = 1'b1; start2 = 1'b1;
        repeat (4) begin
            @(posedge clock); #1;
            start0 = 1'b0; start2 = 1'b0;
        end
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check("midreset", 0, 4'b0000);
        check("midreset", 1, 4'b0000);
        run_job("postreset", 1, 16'h0009, 4, 0, 1'b0, 1'b1);

        for (int k = 0; k < 24; k++) begin
            sel = int'($urandom_range(0, 1));
            pat = WIDTH'($urandom);
            len = int'($urandom_range(0, 20));
            rep = int'($urandom_range(0, 3));
            run_job($sformatf("rnd%0d", k), sel, pat, len, rep, 1'b1, (k % 3) != 0);
        end
        @(posedge clock); #1;
        check("final", 0, 4'b0000);
        check("final", 1, 4'b0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
